// File: rtl/sync_debounce_reg.sv
// -----------------------------------------------------------------------------
// sync_debounce_reg
//
// Multi-channel input conditioner for slow asynchronous signals (photocell
// sensors, push-buttons) feeding the bank queue controller. Each channel runs
// independently through:
//   1. an SYNC_STAGES-deep flip-flop synchroniser,
//   2. a debounce counter that accepts a new level only after it has persisted
//      for DEBOUNCE_CYCLES consecutive enabled cycles,
//   3. a registered stable level plus one-cycle rise/fall pulses.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      synchronous active-low reset
//   en    in   1      filter enable; when low, counters and dout hold and the
//                     pulses are forced to 0 (the synchroniser keeps shifting)
//   din   in   WIDTH  raw asynchronous inputs
//   dout  out  WIDTH  debounced, registered level
//   rise  out  WIDTH  one-cycle pulse on dout[i] 0->1
//   fall  out  WIDTH  one-cycle pulse on dout[i] 1->0
// -----------------------------------------------------------------------------
module sync_debounce_reg #(
  parameter int unsigned      WIDTH           = 2,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Stage 0 samples din; stage SYNC_STAGES-1 is the synchronised level.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  dout_q, dout_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;

    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_lvl[i] == dout_q[i]) begin
          // Level matches the accepted one: any partial count was a glitch.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          dout_d[i] = sync_lvl[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_lvl[i];
          fall_d[i] = ~sync_lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      // Synchroniser is preloaded with RESET_VAL so a din that already differs
      // at release is seen as a normal, fully-latent transition.
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      cnt_q  <= '0;
      dout_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_sync_debounce_reg.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce_reg
//
// Directed bench for sync_debounce_reg. Instance dut uses default parameters
// (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0); instance dut_p
// uses WIDTH=4, SYNC_STAGES=3, DEBOUNCE_CYCLES=1, RESET_VAL=4'b1010.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so after tick number k the outputs reflect edge k.
// -----------------------------------------------------------------------------
module tb_sync_debounce_reg;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] din, dout, rise, fall;

  logic       rst_p, en_p;
  logic [3:0] din_p, dout_p, rise_p, fall_p;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_debounce_reg dut (
    .clk (clk), .rst (rst), .en (en), .din (din),
    .dout(dout), .rise(rise), .fall(fall)
  );

  sync_debounce_reg #(
    .WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'b1010)
  ) dut_p (
    .clk (clk), .rst (rst_p), .en (en_p), .din (din_p),
    .dout(dout_p), .rise(rise_p), .fall(fall_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; din = 2'b11;
    repeat (3) tick();
    total++; if (dout !== 2'b00) $display("FAIL reset_dout: got %b want 00", dout); else passed++;
    total++; if (rise !== 2'b00) $display("FAIL reset_rise: got %b want 00", rise); else passed++;
    total++; if (fall !== 2'b00) $display("FAIL reset_fall: got %b want 00", fall); else passed++;
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        total++; if (dout !== 2'b00 || rise !== 2'b00)
          $display("FAIL release_early: dout=%b rise=%b want 00/00", dout, rise); else passed++;
      end
      if (k == 6) begin
        total++; if (dout !== 2'b11) $display("FAIL release_dout: got %b want 11", dout); else passed++;
        total++; if (rise !== 2'b11) $display("FAIL release_rise: got %b want 11", rise); else passed++;
      end
      if (k == 7) begin
        total++; if (rise !== 2'b00 || dout !== 2'b11)
          $display("FAIL release_pulse_end: rise=%b dout=%b want 00/11", rise, dout); else passed++;
      end
    end
    // Return both channels low for the next scenario.
    din = 2'b00;
    repeat (8) tick();
    total++; if (dout !== 2'b00) $display("FAIL settle_low: got %b want 00", dout); else passed++;
  endtask

  task automatic test_clean_edge();
    din = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        total++; if (dout !== 2'b00) $display("FAIL clean_rise_early: got %b want 00", dout); else passed++;
      end
      if (k == 6) begin
        total++; if (dout !== 2'b01 || rise !== 2'b01 || fall !== 2'b00)
          $display("FAIL clean_rise: dout=%b rise=%b fall=%b want 01/01/00", dout, rise, fall); else passed++;
      end
      if (k == 7) begin
        total++; if (rise !== 2'b00) $display("FAIL clean_rise_width: got %b want 00", rise); else passed++;
      end
    end
    din = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        total++; if (dout !== 2'b01 || fall !== 2'b00)
          $display("FAIL clean_fall_early: dout=%b fall=%b want 01/00", dout, fall); else passed++;
      end
      if (k == 6) begin
        total++; if (dout !== 2'b00 || fall !== 2'b01 || rise !== 2'b00)
          $display("FAIL clean_fall: dout=%b fall=%b rise=%b want 00/01/00", dout, fall, rise); else passed++;
      end
      if (k == 7) begin
        total++; if (fall !== 2'b00) $display("FAIL clean_fall_width: got %b want 00", fall); else passed++;
      end
    end
  endtask

  task automatic test_glitch();
    // Three high cycles reach cnt=3 but never complete the count.
    din = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) din = 2'b00;
      tick();
      total++; if (dout !== 2'b00 || rise !== 2'b00 || fall !== 2'b00)
        $display("FAIL glitch_reject[%0d]: dout=%b rise=%b fall=%b want 00/00/00", k, dout, rise, fall);
      else passed++;
    end
    // Four high cycles are accepted, then the low level is accepted after 4 more.
    din = 2'b10;
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) din = 2'b00;
      tick();
      if (k == 5) begin
        total++; if (dout !== 2'b00) $display("FAIL glitch4_early: got %b want 00", dout); else passed++;
      end
      if (k == 6) begin
        total++; if (dout !== 2'b10 || rise !== 2'b10)
          $display("FAIL glitch4_rise: dout=%b rise=%b want 10/10", dout, rise); else passed++;
      end
      if (k == 9) begin
        total++; if (dout !== 2'b10 || fall !== 2'b00)
          $display("FAIL glitch4_hold: dout=%b fall=%b want 10/00", dout, fall); else passed++;
      end
      if (k == 10) begin
        total++; if (dout !== 2'b00 || fall !== 2'b10)
          $display("FAIL glitch4_fall: dout=%b fall=%b want 00/10", dout, fall); else passed++;
      end
      if (k == 11) begin
        total++; if (fall !== 2'b00) $display("FAIL glitch4_fall_width: got %b want 00", fall); else passed++;
      end
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b0; din = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (dout !== 2'b00 || rise !== 2'b00 || fall !== 2'b00)
        $display("FAIL en_hold[%0d]: dout=%b rise=%b fall=%b want 00/00/00", k, dout, rise, fall);
      else passed++;
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin
        total++; if (dout !== 2'b00) $display("FAIL en_resume_early: got %b want 00", dout); else passed++;
      end
      if (k == 4) begin
        total++; if (dout !== 2'b11 || rise !== 2'b11)
          $display("FAIL en_resume: dout=%b rise=%b want 11/11", dout, rise); else passed++;
      end
      if (k == 5) begin
        total++; if (rise !== 2'b00) $display("FAIL en_resume_width: got %b want 00", rise); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    din = 2'b00;
    repeat (8) tick();
    total++; if (dout !== 2'b00) $display("FAIL midrst_settle: got %b want 00", dout); else passed++;
    din = 2'b11;
    repeat (4) tick();   // cnt has reached 2
    rst = 1'b0;
    tick();
    total++; if (dout !== 2'b00 || rise !== 2'b00)
      $display("FAIL midrst_apply: dout=%b rise=%b want 00/00", dout, rise); else passed++;
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        total++; if (dout !== 2'b00) $display("FAIL midrst_restart: got %b want 00", dout); else passed++;
      end
      if (k == 6) begin
        total++; if (dout !== 2'b11 || rise !== 2'b11)
          $display("FAIL midrst_done: dout=%b rise=%b want 11/11", dout, rise); else passed++;
      end
    end
  endtask

  task automatic test_param_sweep();
    rst_p = 1'b0; en_p = 1'b1; din_p = 4'b0101;
    repeat (2) tick();
    total++; if (dout_p !== 4'b1010 || rise_p !== 4'b0000 || fall_p !== 4'b0000)
      $display("FAIL sweep_reset: dout=%b rise=%b fall=%b want 1010/0000/0000", dout_p, rise_p, fall_p);
    else passed++;
    rst_p = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin
        total++; if (dout_p !== 4'b1010) $display("FAIL sweep_early: got %b want 1010", dout_p); else passed++;
      end
      if (k == 4) begin
        total++; if (dout_p !== 4'b0101) $display("FAIL sweep_dout: got %b want 0101", dout_p); else passed++;
        total++; if (rise_p !== 4'b0101 || fall_p !== 4'b1010)
          $display("FAIL sweep_pulses: rise=%b fall=%b want 0101/1010", rise_p, fall_p); else passed++;
      end
      if (k == 5) begin
        total++; if (rise_p !== 4'b0000 || fall_p !== 4'b0000)
          $display("FAIL sweep_pulse_width: rise=%b fall=%b want 0000/0000", rise_p, fall_p); else passed++;
      end
    end
    // With no filtering, a one-cycle din change still reaches dout.
    din_p = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        total++; if (dout_p !== 4'b0100 || fall_p !== 4'b0001)
          $display("FAIL sweep_d1_follow: dout=%b fall=%b want 0100/0001", dout_p, fall_p); else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; din = 2'b00;
    rst_p = 1'b0; en_p = 1'b1; din_p = 4'b0000;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_enable_hold();
    test_reset_mid_count();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
